// File: rtl/rate_pkg.sv
// Shared types and constants for the rate sequencer: FSM encoding, rate codes,
// and the half-period / terminal-count helpers derived from the clock frequency.
package rate_pkg;

    localparam int CNT_W = 28;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [1:0] RATE_0P25HZ = 2'd0;
    localparam logic [1:0] RATE_0P5HZ  = 2'd1;
    localparam logic [1:0] RATE_1HZ    = 2'd2;
    localparam logic [1:0] RATE_2HZ    = 2'd3;
    localparam logic [1:0] RATE_MAX    = RATE_2HZ;

    function automatic cnt_t half_period(input int unsigned clk_hz, input logic [1:0] code);
        case (code)
            RATE_0P25HZ: return cnt_t'(clk_hz * 2);
            RATE_0P5HZ:  return cnt_t'(clk_hz);
            RATE_1HZ:    return cnt_t'(clk_hz / 2);
            default:     return cnt_t'(clk_hz / 4);
        endcase
    endfunction

    function automatic cnt_t terminal_count(input int unsigned clk_hz, input logic [1:0] code);
        return half_period(clk_hz, code) - cnt_t'(1);
    endfunction

endpackage

// File: rtl/period_counter.sv
// Half-period counter: counts while enabled, wraps to zero at the terminal count.
// Clear has priority over enable so the FSM can zero it from any state.
module period_counter
    import rate_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    input  cnt_t tc,
    output cnt_t count,
    output logic at_tc
);

    assign at_tc = (count == tc);

    always_ff @(posedge clk) begin
        if (!reset || clr)
            count <= '0;
        else if (en)
            count <= at_tc ? '0 : count + cnt_t'(1);
    end

endmodule

// File: rtl/rate_sequencer.sv
// Rate sequencer: IDLE/RUN/HOLD controller driving a square wave and a rising-edge
// tick at one of four rates, with deferred speed-up applied at the next half-period end.
module rate_sequencer
    import rate_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic [1:0] speed_sel,
    input  logic       speed_up,
    output logic       tick,
    output logic       phase,
    output logic [1:0] level,
    output logic       running
);

    state_t state, state_nxt;
    cnt_t   count, tc;
    logic   at_tc, pending, advance, clr;

    // Level only moves on a terminal-count edge, so the counter never overshoots tc.
    assign tc      = terminal_count(CLK_HZ, level);
    assign advance = (state == ST_RUN) && !stop;
    assign clr     = (state == ST_IDLE) || ((state == ST_HOLD) && stop);

    period_counter u_cnt (
        .clk   (CLOCK_50),
        .reset (reset),
        .en    (advance),
        .clr   (clr),
        .tc    (tc),
        .count (count),
        .at_tc (at_tc)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start && !stop) state_nxt = ST_RUN;
            ST_RUN:  if (stop)           state_nxt = ST_HOLD;
            ST_HOLD: begin
                if (stop)       state_nxt = ST_IDLE;
                else if (start) state_nxt = ST_RUN;
            end
            default:            state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        running = (state == ST_RUN);
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            phase   <= 1'b0;
            tick    <= 1'b0;
            level   <= RATE_0P25HZ;
            pending <= 1'b0;
        end else begin
            tick <= 1'b0;
            case (state)
                ST_IDLE: begin
                    phase   <= 1'b0;
                    pending <= 1'b0;
                    if (start && !stop) level <= speed_sel;
                end
                ST_RUN: if (!stop) begin
                    if (at_tc) begin
                        phase <= !phase;
                        tick  <= !phase;
                        if (pending) begin
                            level   <= level + 2'd1;
                            pending <= 1'b0;
                        end
                    end
                    // A request landing on the wrap edge waits for the following one.
                    if (speed_up && !pending && level != RATE_MAX)
                        pending <= 1'b1;
                end
                ST_HOLD: if (stop) begin
                    phase   <= 1'b0;
                    pending <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rate_sequencer.sv
// Directed bench for rate_sequencer at CLK_HZ=8 (half periods 16/8/4/2 cycles).
module tb_rate_sequencer;

    logic       CLOCK_50 = 1'b0;
    logic       reset, start, stop, speed_up;
    logic [1:0] speed_sel;
    logic       tick, phase, running;
    logic [1:0] level;

    int n_chk = 0;
    int n_err = 0;

    rate_sequencer #(.CLK_HZ(8)) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .speed_sel (speed_sel),
        .speed_up  (speed_up),
        .tick      (tick),
        .phase     (phase),
        .level     (level),
        .running   (running)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic step(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic t, input logic p,
                           input logic r, input logic [1:0] l);
        chk({tag, ".tick"},    32'(tick),    32'(t));
        chk({tag, ".phase"},   32'(phase),   32'(p));
        chk({tag, ".running"}, 32'(running), 32'(r));
        chk({tag, ".level"},   32'(level),   32'(l));
    endtask

    initial begin
        int t1, t2, hi, bad;

        reset = 1'b0; start = 1'b1; stop = 1'b0; speed_sel = 2'd3; speed_up = 1'b0;
        step(2);
        chk_out("reset", 1'b0, 1'b0, 1'b0, 2'd0);

        // level 3: phase rises 2 cycles after entering RUN, tick every 4
        reset = 1'b1;
        step(1);
        start = 1'b0;
        chk_out("l3_enter", 1'b0, 1'b0, 1'b1, 2'd3);
        step(1);
        chk("l3_e1_phase", 32'(phase), 0);
        step(1);
        chk("l3_e2_phase", 32'(phase), 1);
        chk("l3_e2_tick",  32'(tick),  1);
        for (int i = 1; i <= 8; i++) begin
            step(1);
            chk("l3_tick",  32'(tick),  32'((i % 4) == 0));
            chk("l3_phase", 32'(phase), 32'(((i / 2) % 2) == 0));
        end
        stop = 1'b1; step(2); stop = 1'b0;
        chk_out("l3_idle", 1'b0, 1'b0, 1'b0, 2'd3);

        // level 0: 32-cycle period, phase high for 16
        speed_sel = 2'd0; start = 1'b1; step(1); start = 1'b0;
        t1 = -1; t2 = -1; hi = 0;
        for (int i = 1; i <= 48; i++) begin
            step(1);
            if (tick) begin
                if (t1 < 0) t1 = i;
                else if (t2 < 0) t2 = i;
            end
            if (i >= 16 && i < 48 && phase) hi++;
        end
        chk("l0_first_tick",  32'(t1), 16);
        chk("l0_second_tick", 32'(t2), 48);
        chk("l0_phase_high",  32'(hi), 16);
        stop = 1'b1; step(2); stop = 1'b0;

        // deferred speed-up from level 1, then saturation at level 3
        speed_sel = 2'd1; start = 1'b1; step(1); start = 1'b0;
        step(3);
        speed_up = 1'b1; step(1); speed_up = 1'b0;
        step(3);
        chk("su_e7_level", 32'(level), 1);
        chk("su_e7_phase", 32'(phase), 0);
        step(1);
        chk_out("su_e8", 1'b1, 1'b1, 1'b1, 2'd2);
        step(4);
        chk("su_e12_phase", 32'(phase), 0);
        step(4);
        chk("su_e16_phase", 32'(phase), 1);
        chk("su_e16_tick",  32'(tick),  1);
        speed_up = 1'b1;
        step(3);
        chk("su_e19_level", 32'(level), 2);
        step(1);
        chk("su_e20_level", 32'(level), 3);
        chk("su_e20_phase", 32'(phase), 0);
        step(2);
        speed_up = 1'b0;
        chk("su_e22_phase", 32'(phase), 1);
        chk("su_e22_tick",  32'(tick),  1);
        step(4);
        chk("su_sat_level", 32'(level), 3);
        chk("su_e26_phase", 32'(phase), 1);
        stop = 1'b1; step(2); stop = 1'b0;
        chk_out("su_idle", 1'b0, 1'b0, 1'b0, 2'd3);

        // pause at counter=1 on level 2, resume continues from frozen count
        speed_sel = 2'd2; start = 1'b1; step(1); start = 1'b0;
        step(1);
        stop = 1'b1; step(1); stop = 1'b0;
        chk("hold_running", 32'(running), 0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (phase || tick || running || level != 2'd2) bad++;
        end
        chk("hold_frozen", 32'(bad), 0);
        start = 1'b1; step(1); start = 1'b0;
        chk("resume_running", 32'(running), 1);
        step(2);
        chk("resume_r2_phase", 32'(phase), 0);
        step(1);
        chk("resume_r3_phase", 32'(phase), 1);
        chk("resume_r3_tick",  32'(tick),  1);
        stop = 1'b1; step(2); stop = 1'b0;
        chk_out("hold_idle", 1'b0, 1'b0, 1'b0, 2'd2);

        // start+stop together in IDLE, speed_up in IDLE ignored
        start = 1'b1; stop = 1'b1; speed_up = 1'b1; speed_sel = 2'd1;
        step(3);
        chk_out("both_idle", 1'b0, 1'b0, 1'b0, 2'd2);
        start = 1'b0; stop = 1'b0; speed_up = 1'b0;

        // reset one cycle before a due tick
        speed_sel = 2'd3; start = 1'b1; step(1); start = 1'b0;
        step(1);
        reset = 1'b0; step(1);
        chk_out("rst_tick", 1'b0, 1'b0, 1'b0, 2'd0);
        reset = 1'b1; step(2);
        chk_out("rst_after", 1'b0, 1'b0, 1'b0, 2'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/rate_sequencer.md
RATE_SEQUENCER -- requirements
Module: rate_sequencer

Interface
REQ-001 Parameter CLK_HZ SHALL default to 50_000_000 and give the input clock frequency in Hz.
REQ-002 CLOCK_50  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; SHALL be sampled only on the CLOCK_50 rising edge.
REQ-004 start  input  1  level-sampled start/resume request.
REQ-005 stop  input  1  level-sampled pause/abort request.
REQ-006 speed_sel  input  2  initial rate code: 0=0.25 Hz, 1=0.5 Hz, 2=1 Hz, 3=2 Hz.
REQ-007 speed_up  input  1  request to advance the rate by one code.
REQ-008 tick  output  1  one-cycle pulse, once per period of the active rate.
REQ-009 phase  output  1  square wave at the active rate, 50% duty.
REQ-010 level  output  2  active rate code.
REQ-011 running  output  1  high only in state RUN.

Function
REQ-012 Half-period lengths SHALL be H(code) = CLK_HZ*2, CLK_HZ, CLK_HZ/2 and CLK_HZ/4 cycles for codes 0 to 3; terminal count TC = H-1.
REQ-013 The period counter SHALL be 28 bits wide, unsigned, and hold all TC values for CLK_HZ=50_000_000 (max 99_999_999).
REQ-014 The FSM SHALL have three states, IDLE, RUN and HOLD, with IDLE as the reset state.
REQ-015 IDLE: counter=0, phase=0, tick=0; start=1 and stop=0 SHALL latch level<=speed_sel and go to RUN.
REQ-016 RUN: the counter SHALL increment each cycle; at counter==TC(level) it SHALL clear to 0 and toggle phase.
REQ-017 tick SHALL be 1 for exactly the cycle in which phase is 1 and was 0 on the previous cycle.
REQ-018 The first phase toggle after entering RUN from IDLE SHALL occur H(level) cycles after the transition edge.
REQ-019 speed_up in RUN with level<3 SHALL set a pending flag; the increment SHALL apply on the next counter==TC edge, together with the phase toggle.
REQ-020 speed_up at level=3, or while a pending increment exists, SHALL be ignored (saturation; no double step).
REQ-021 speed_up in IDLE or HOLD SHALL be ignored.
REQ-022 RUN with stop=1 SHALL go to HOLD with counter, phase, level and pending flag frozen; tick=0 in HOLD.
REQ-023 HOLD with start=1 and stop=0 SHALL return to RUN and continue counting from the frozen counter value.
REQ-024 HOLD with stop=1 SHALL go to IDLE, clearing counter, phase and the pending flag; level SHALL be retained.
REQ-025 When start and stop are both 1, stop SHALL win in every state.
REQ-026 The counter SHALL never exceed TC(level), because level changes only at a terminal count.

Reset
REQ-027 With reset=0 at a clock edge, the next state SHALL be state=IDLE, counter=0, phase=0, tick=0, level=0, running=0 and pending=0, regardless of the current state.
REQ-028 Reset asserted mid-RUN SHALL suppress any tick or toggle that would otherwise occur on that edge.

Structure
REQ-029 Package rate_pkg SHALL hold the FSM state encoding, the rate-code constants and the half-period function of CLK_HZ and code.
REQ-030 One sub-module, period_counter, SHALL hold the 28-bit counter with enable, clear and terminal-count compare; the FSM and the level/pending logic SHALL stay in rate_sequencer.

Verification (CLK_HZ=8, giving H = 16/8/4/2)
REQ-031 Assert reset=0 for 2 cycles with start=1 -> all outputs 0, state IDLE.
REQ-032 speed_sel=3, start pulsed 1 cycle -> running=1; phase rises 2 cycles after the transition edge; tick then repeats every 4 cycles.
REQ-033 speed_sel=0, start -> tick period 32 cycles, phase high for 16 cycles.
REQ-034 Level 1 (H=8), speed_up at counter=3 -> level stays 1 until counter==7, then becomes 2; phase then toggles every 4 cycles; at level 3, speed_up leaves level=3.
REQ-035 Level 2, stop at counter=1, held 10 cycles, then start -> phase frozen, no tick; the next toggle occurs 3 cycles after resume; stop in HOLD -> IDLE with level retained.
REQ-036 start=stop=1 in IDLE -> stays IDLE; reset=0 one cycle before a due tick -> no tick, all outputs 0.
